// File: rtl/uart_arb_pkg.sv
// Shared types for the UART command arbiter: FSM states, latched command
// record and the default WAIT timeout.
package uart_arb_pkg;

  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } arb_cmd_t;

endpackage

// File: rtl/uart_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above
// ptr_i, wrapping past NREQ-1. Produces a one-hot grant and its index.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  always_comb begin : p_pick
    int cand;
    // NOTE: every output gets a default before the search loop, so no path
    // leaves a value unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o                = 1'b1;
        idx_o                = cand[IW-1:0];
        gnt_o[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite master command port between NREQ
// requesters. Optional WAIT timeout is enabled with the ARB_TIMEOUT_EN macro.
module uart_cmd_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*32-1:0]      req_addr,
  input  logic [NREQ*32-1:0]      req_data,
  input  logic [NREQ*4-1:0]       req_wstrb,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    start_read,
  output logic                    start_write,
  output logic [31:0]             addr,
  output logic [31:0]             data,
  output logic [3:0]              wstrb,
  input  logic                    m_done,
  input  logic [31:0]             m_rdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    state_q, state_d;
  arb_cmd_t      cmd_q, cmd_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [31:0]   rdata_q, rdata_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
`endif

  arb_cmd_t        req_cmd [NREQ];
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign req_cmd[g] = '{write: req_write[g],
                          addr:  req_addr[g*32 +: 32],
                          data:  req_data[g*32 +: 32],
                          wstrb: req_wstrb[g*4 +: 4]};
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
    req_ready   = '0;
    rsp_valid   = '0;
    start_read  = 1'b0;
    start_write = 1'b0;
`ifdef ARB_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          cmd_d     = req_cmd[pick_idx];
          grant_d   = pick_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_write = cmd_q.write;
        start_read  = !cmd_q.write;
        state_d     = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      ST_WAIT: begin
        // m_done wins over a timeout landing in the same cycle.
        if (m_done) begin
          rdata_d = cmd_q.write ? 32'd0 : m_rdata;
          state_d = ST_RESP;
`ifdef ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == TMO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      ST_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign addr      = cmd_q.addr;
  assign data      = cmd_q.data;
  assign wstrb     = cmd_q.wstrb;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;
`ifdef ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
